pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with 2-entry skid buffer, flush and optional perf counters (PIPE_REG_PERF_EN).
module pipe_stage_reg #(
  parameter int KEEP_W = 32,
  parameter int CLR_W  = 128
`ifdef PIPE_REG_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [KEEP_W-1:0] in_keep_i,
  input  logic [CLR_W-1:0]  in_clr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [KEEP_W-1:0] out_keep_o,
  output logic [CLR_W-1:0]  out_clr_o
`ifdef PIPE_REG_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e state_q, state_d;
  logic [KEEP_W-1:0] main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
  logic [CLR_W-1:0]  main_clr_q, main_clr_d, skid_clr_q, skid_clr_d;
  logic push, pop;
  assign in_ready_o  = state_q != FULL;
  assign out_valid_o = state_q != EMPTY;
  assign out_keep_o  = main_keep_q;
  assign out_clr_o   = main_clr_q;
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;
  // main.clr and skid are kept zero whenever invalid so outputs need no masking
  always_comb begin
    state_d     = state_q;
    main_keep_d = main_keep_q;
    main_clr_d  = main_clr_q;
    skid_keep_d = skid_keep_q;
    skid_clr_d  = skid_clr_q;
    if (flush_i) begin
      state_d     = EMPTY;
      main_keep_d = in_valid_i ? in_keep_i : main_keep_q;
      main_clr_d  = '0;
      skid_keep_d = '0;
      skid_clr_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d     = ONE;
          main_keep_d = in_keep_i;
          main_clr_d  = in_clr_i;
        end
        ONE: if (push && pop) begin
          main_keep_d = in_keep_i;
          main_clr_d  = in_clr_i;
        end else if (push) begin
          state_d     = FULL;
          skid_keep_d = in_keep_i;
          skid_clr_d  = in_clr_i;
        end else if (pop) begin
          state_d    = EMPTY;
          main_clr_d = '0;
        end
        FULL: if (pop) begin
          state_d     = ONE;
          main_keep_d = skid_keep_q;
          main_clr_d  = skid_clr_q;
          skid_keep_d = '0;
          skid_clr_d  = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_keep_q <= '0;
      main_clr_q  <= '0;
      skid_keep_q <= '0;
      skid_clr_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_keep_q <= main_keep_d;
      main_clr_q  <= main_clr_d;
      skid_keep_q <= skid_keep_d;
      skid_clr_q  <= skid_clr_d;
    end
  end
`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    stall_cnt_d  = (out_valid_o && !out_ready_i && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    bubble_cnt_d = (!out_valid_o && !(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg with a FIFO scoreboard.
module tb_pipe_stage_reg;
  localparam int K = 32;
  localparam int C = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [K-1:0] in_keep_i = '0;
  logic [C-1:0] in_clr_i = '0;
  logic out_valid_o;
  logic out_ready_i = 1'b0;
  logic [K-1:0] out_keep_o;
  logic [C-1:0] out_clr_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [K+C-1:0] sb_q[$];
  always #5 clk = ~clk;
`ifdef PIPE_REG_PERF_EN
  logic [3:0] stall_cnt_o, bubble_cnt_o;
  pipe_stage_reg #(.KEEP_W(K), .CLR_W(C), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_keep_i(in_keep_i), .in_clr_i(in_clr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_keep_o(out_keep_o), .out_clr_o(out_clr_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o));
`else
  pipe_stage_reg #(.KEEP_W(K), .CLR_W(C)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_keep_i(in_keep_i), .in_clr_i(in_clr_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_keep_o(out_keep_o), .out_clr_o(out_clr_o));
`endif
  task automatic chk(input string tag, input logic [K+C-1:0] got, input logic [K+C-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // scoreboard: decide at negedge what the coming posedge will push/pop
  always @(negedge clk) begin
    if (!out_valid_o) chk("clr_zero_idle", out_clr_o, '0);
    if (rst || flush_i) sb_q.delete();
    else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_data", {out_keep_o, out_clr_o}, sb_q.pop_front());
      end
      if (in_valid_i && in_ready_o) sb_q.push_back({in_keep_i, in_clr_i});
    end
  end
  initial begin
    int id;
    int w;
    #1;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'($urandom);
      flush_i = 1'($urandom);
      out_ready_i = 1'($urandom);
      in_keep_i = $urandom;
      in_clr_i = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("rst_valid", out_valid_o, 0);
    chk("rst_keep", out_keep_o, 0);
    chk("rst_clr", out_clr_o, 0);
    chk("rst_ready", in_ready_o, 1);
    rst = 0; flush_i = 0; in_valid_i = 0; out_ready_i = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1; in_keep_i = 32'h100 + 4 * i; in_clr_i = C'(32'hA + i);
      step();
      chk("t2_valid", out_valid_o, 1);
      chk("t2_keep", out_keep_o, 32'h100 + 4 * i);
      chk("t2_clr", out_clr_o, C'(32'hA + i));
    end
    in_valid_i = 0;
    step();
    chk("t2_drained", out_valid_o, 0);
    out_ready_i = 0;
    in_valid_i = 1; in_keep_i = 32'h200; in_clr_i = C'(1); step();
    chk("t3_ready_one", in_ready_o, 1);
    in_keep_i = 32'h204; in_clr_i = C'(2); step();
    chk("t3_ready_full", in_ready_o, 0);
    in_keep_i = 32'h208; in_clr_i = C'(3); step(); step();
    chk("t3_ready_held", in_ready_o, 0);
    chk("t3_head_held", out_keep_o, 32'h200);
    out_ready_i = 1; step();
    chk("t3_out1", out_keep_o, 32'h204);
    step();
    in_valid_i = 0;
    chk("t3_out2", out_keep_o, 32'h208);
    step();
    chk("t3_empty", out_valid_o, 0);
    out_ready_i = 0;
    in_valid_i = 1; in_keep_i = 32'h250; in_clr_i = C'(5); step();
    in_keep_i = 32'h254; in_clr_i = C'(6); step();
    chk("t4_full", in_ready_o, 0);
    flush_i = 1; in_keep_i = 32'h300; in_clr_i = C'(7); step();
    flush_i = 0; in_valid_i = 0;
    chk("t4_valid", out_valid_o, 0);
    chk("t4_clr", out_clr_o, 0);
    chk("t4_keep", out_keep_o, 32'h300);
    chk("t4_ready", in_ready_o, 1);
    rst = 1; flush_i = 1; in_valid_i = 1; in_keep_i = 32'h400; step();
    rst = 0; flush_i = 0; in_valid_i = 0;
    chk("t5_keep", out_keep_o, 0);
    chk("t5_valid", out_valid_o, 0);
    chk("t5_ready", in_ready_o, 1);
`ifdef PIPE_REG_PERF_EN
    in_valid_i = 1; in_keep_i = 32'h500; in_clr_i = C'(8); step();
    in_valid_i = 0;
    for (int i = 0; i < 5; i++) step();
    chk("t6_stall5", stall_cnt_o, 5);
    for (int i = 0; i < 20; i++) step();
    chk("t6_stall_sat", stall_cnt_o, 15);
    chk("t6_bubble", bubble_cnt_o, 1);
    flush_i = 1; step(); flush_i = 0;
    chk("t6_flush_keeps_cnt", stall_cnt_o, 15);
`endif
    id = 0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid_i || in_ready_o || flush_i) begin
        in_valid_i = 1'($urandom_range(0, 2) != 0);
        in_keep_i = 32'h1000 + id;
        in_clr_i = {32'(id), $urandom, $urandom, $urandom};
        id++;
      end
      out_ready_i = 1'($urandom_range(0, 2) != 0);
      flush_i = $urandom_range(0, 40) == 0;
      step();
    end
    in_valid_i = 0; flush_i = 0; out_ready_i = 1;
    w = 0;
    while ((sb_q.size() != 0 || out_valid_o) && w < 10) begin
      step();
      w++;
    end
    chk("drain_sb", sb_q.size(), 0);
    chk("drain_valid", out_valid_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
